// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage
// Holds the architectural program counter and the IF/ID boundary register.
// The sequential next PC comes from an external adder: this block drives the
// adder with the current PC and the step, and takes the sum back. It also
// handles the hazard stall, branch/exception redirect with IF/ID flush, and
// the one-cycle boot bubble after reset. A saturating counter records how
// many cycles the hazard unit held the front end.
module pc_fetch_stage #(
    parameter int                    ADDR_WIDTH  = 64,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    INCREMENT   = 4,
    parameter int                    STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_target,
    output logic [ADDR_WIDTH-1:0]  adder_a,
    output logic [ADDR_WIDTH-1:0]  adder_b,
    input  logic [ADDR_WIDTH-1:0]  adder_sum,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    output logic [ADDR_WIDTH-1:0]  ifid_pc,
    output logic                   ifid_valid,
    output logic                   misalign_flag,
    output logic [STALL_CNT_W-1:0] stall_count
);

    // Step fed to the external adder, zero-extended to the address width.
    localparam logic [ADDR_WIDTH-1:0] LP_INCREMENT = ADDR_WIDTH'(INCREMENT);

    // BOOT marks the first fetch cycle after reset, when IF/ID is still the
    // bubble left by reset; RUN is normal operation.
    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 r_state;
    logic [ADDR_WIDTH-1:0]  r_pc;
    logic [ADDR_WIDTH-1:0]  r_ifid_pc;
    logic                   r_ifid_valid;
    logic                   r_misalign;
    logic [STALL_CNT_W-1:0] r_stall_count;

    state_t                 w_state_next;
    logic [ADDR_WIDTH-1:0]  w_pc_next;
    logic [ADDR_WIDTH-1:0]  w_ifid_pc_next;
    logic                   w_ifid_valid_next;
    logic                   w_misalign_next;
    logic [STALL_CNT_W-1:0] w_stall_count_next;

    // Redirect targets are word aligned by dropping the two low bits; the
    // dropped bits are reported through the misalign pulse instead.
    logic [ADDR_WIDTH-1:0]  w_redirect_pc;
    logic                   w_target_misaligned;
    logic                   w_stall_saturated;

    assign w_redirect_pc       = {redirect_target[ADDR_WIDTH-1:2], 2'b00};
    assign w_target_misaligned = (redirect_target[1:0] != 2'b00);
    assign w_stall_saturated   = (r_stall_count == {STALL_CNT_W{1'b1}});

    // The only combinational outputs: the current PC and the constant step.
    assign adder_a   = r_pc;
    assign imem_addr = r_pc;
    assign adder_b   = LP_INCREMENT;

    assign ifid_pc       = r_ifid_pc;
    assign ifid_valid    = r_ifid_valid;
    assign misalign_flag = r_misalign;
    assign stall_count   = r_stall_count;

    // Register all front-end state; reset wins over every other input.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (reset) begin
            r_state       <= ST_BOOT;
            r_pc          <= RESET_PC;
            r_ifid_pc     <= '0;
            r_ifid_valid  <= 1'b0;
            r_misalign    <= 1'b0;
            r_stall_count <= '0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_ifid_pc     <= w_ifid_pc_next;
            r_ifid_valid  <= w_ifid_valid_next;
            r_misalign    <= w_misalign_next;
            r_stall_count <= w_stall_count_next;
        end
    end

    // Next-state and next PC/IF-ID values; priority is redirect > stall > advance.
    always_comb begin
        // NOTE: every signal gets a hold/default value first so that no path
        // through the case leaves it unassigned, which would infer a latch.
        w_state_next      = r_state;
        w_pc_next         = r_pc;
        w_ifid_pc_next    = r_ifid_pc;
        w_ifid_valid_next = r_ifid_valid;
        w_misalign_next   = 1'b0;

        case (r_state)
            ST_BOOT: begin
                if (redirect_valid) begin
                    w_pc_next         = w_redirect_pc;
                    w_ifid_valid_next = 1'b0;
                    w_misalign_next   = w_target_misaligned;
                    w_state_next      = ST_RUN;
                end else if (!stall) begin
                    w_pc_next         = adder_sum;
                    w_ifid_pc_next    = r_pc;
                    w_ifid_valid_next = 1'b1;
                    w_state_next      = ST_RUN;
                end
                // A stall in BOOT holds the PC and keeps the bubble.
            end

            ST_RUN: begin
                if (redirect_valid) begin
                    // Flush the wrong-path instruction; ifid_pc keeps its value.
                    w_pc_next         = w_redirect_pc;
                    w_ifid_valid_next = 1'b0;
                    w_misalign_next   = w_target_misaligned;
                end else if (!stall) begin
                    w_pc_next         = adder_sum;
                    w_ifid_pc_next    = r_pc;
                    w_ifid_valid_next = 1'b1;
                end
            end

            default: begin
                w_state_next = ST_BOOT;
            end
        endcase
    end

    // Count every stalled cycle, including redirect-with-stall, without wrapping.
    always_comb begin
        w_stall_count_next = r_stall_count;
        if (stall && !w_stall_saturated) begin
            w_stall_count_next = r_stall_count + STALL_CNT_W'(1);
        end
    end

endmodule
